// File: rtl/memmu_sr_pkg.sv
// rtl/memmu_sr_pkg.sv - shared field layout, payload struct and unpacker state type for MemMU SR payloads
package memmu_sr_pkg;

  localparam int DIST_W    = 16;
  localparam int REFL_W    = 8;
  localparam int CORR_W    = 8;
  localparam int LABEL_W   = 8;
  localparam int PAYLOAD_W = 64;

  // Field offsets inside the 64-bit payload word
  localparam int DIST_R0_LSB = 0;
  localparam int REFL_R0_LSB = DIST_R0_LSB + DIST_W;
  localparam int DIST_R1_LSB = REFL_R0_LSB + REFL_W;
  localparam int REFL_R1_LSB = DIST_R1_LSB + DIST_W;
  localparam int CORR_LSB    = REFL_R1_LSB + REFL_W;
  localparam int LABEL_LSB   = CORR_LSB + CORR_W;

  // Layout order, label in the most significant byte
  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [CORR_W-1:0]  correction;
    logic [REFL_W-1:0]  reflR1;
    logic [DIST_W-1:0]  distR1;
    logic [REFL_W-1:0]  reflR0;
    logic [DIST_W-1:0]  distR0;
  } sr_payload_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_R0 = 2'd1,
    EMIT_R1 = 2'd2
  } sr_unpack_state_t;

endpackage

// File: rtl/memmu_sr_payload_unpacker_if.sv
// rtl/memmu_sr_payload_unpacker_if.sv - payload input and point-return output streams (stats ports under MEMMU_SR_U_STATS_EN)
interface memmu_sr_payload_unpacker_if;
  import memmu_sr_pkg::*;

  logic [PAYLOAD_W-1:0] memmuPayload;
  logic                 memmuPayloadValid;
  logic                 memmuPayloadReady;

  logic                 srValid;
  logic                 srReady;
  logic [DIST_W-1:0]    srDist;
  logic [REFL_W-1:0]    srRefl;
  logic                 srReturnIdx;
  logic [CORR_W-1:0]    srCorrection;
  logic [LABEL_W-1:0]   srLabel;
  logic                 srLast;

`ifdef MEMMU_SR_U_STATS_EN
  logic [31:0]          srPayloadCnt;
  logic [31:0]          srBeatCnt;
  logic [15:0]          srEmptyCnt;
`endif

  // Unpacker side
  modport master (
    input  memmuPayload, memmuPayloadValid, srReady,
    output memmuPayloadReady, srValid, srDist, srRefl, srReturnIdx,
           srCorrection, srLabel, srLast
`ifdef MEMMU_SR_U_STATS_EN
    , output srPayloadCnt, srBeatCnt, srEmptyCnt
`endif
  );

  // Environment side: payload source and beat sink
  modport slave (
    output memmuPayload, memmuPayloadValid, srReady,
    input  memmuPayloadReady, srValid, srDist, srRefl, srReturnIdx,
           srCorrection, srLabel, srLast
`ifdef MEMMU_SR_U_STATS_EN
    , input srPayloadCnt, srBeatCnt, srEmptyCnt
`endif
  );

endinterface

// File: rtl/memmu_sr_payload_fields.sv
// rtl/memmu_sr_payload_fields.sv - combinational slicer of a payload word into fields plus return mask
module memmu_sr_payload_fields
  import memmu_sr_pkg::*;
#(
  parameter logic [DIST_W-1:0] DIST_INVALID = 16'h0000,
  parameter bit                SKIP_EMPTY   = 1'b1
) (
  input  logic [PAYLOAD_W-1:0] payload,
  output sr_payload_t          fields,
  output logic                 m0,
  output logic                 m1
);

  assign fields.distR0     = payload[DIST_R0_LSB +: DIST_W];
  assign fields.reflR0     = payload[REFL_R0_LSB +: REFL_W];
  assign fields.distR1     = payload[DIST_R1_LSB +: DIST_W];
  assign fields.reflR1     = payload[REFL_R1_LSB +: REFL_W];
  assign fields.correction = payload[CORR_LSB +: CORR_W];
  assign fields.label      = payload[LABEL_LSB +: LABEL_W];

  // A return is emitted unless skipping is enabled and its distance is the "no return" code
  assign m0 = !SKIP_EMPTY || (fields.distR0 != DIST_INVALID);
  assign m1 = !SKIP_EMPTY || (fields.distR1 != DIST_INVALID);

endmodule

// File: rtl/memmu_sr_payload_unpacker.sv
// rtl/memmu_sr_payload_unpacker.sv - unpacks 64-bit SR payloads into R0/R1 point-return beats; MEMMU_SR_U_STATS_EN adds counters
module memmu_sr_payload_unpacker
  import memmu_sr_pkg::*;
#(
  parameter logic [DIST_W-1:0] DIST_INVALID = 16'h0000,
  parameter bit                SKIP_EMPTY   = 1'b1
) (
  input  logic                         i_SYSTEM_clk,
  input  logic                         i_SYSTEM_rst,
  memmu_sr_payload_unpacker_if.master  bus
);

  sr_payload_t      inFields;
  logic             inM0;
  logic             inM1;

  sr_unpack_state_t state;
  sr_unpack_state_t stateNext;

  // R1 of the current payload waits here while R0 is being presented
  logic               heldM1,    heldM1Next;
  logic [DIST_W-1:0]  heldDist1, heldDist1Next;
  logic [REFL_W-1:0]  heldRefl1, heldRefl1Next;

  logic               outValid,  outValidNext;
  logic [DIST_W-1:0]  outDist,   outDistNext;
  logic [REFL_W-1:0]  outRefl,   outReflNext;
  logic               outIdx,    outIdxNext;
  logic [CORR_W-1:0]  outCorr,   outCorrNext;
  logic [LABEL_W-1:0] outLabel,  outLabelNext;
  logic               outLast,   outLastNext;

  logic handshake;
  logic acceptPayload;

  memmu_sr_payload_fields #(
    .DIST_INVALID (DIST_INVALID),
    .SKIP_EMPTY   (SKIP_EMPTY)
  ) u_fields (
    .payload (bus.memmuPayload),
    .fields  (inFields),
    .m0      (inM0),
    .m1      (inM1)
  );

  assign handshake     = outValid && bus.srReady;
  // A new word is taken when idle, or in the same cycle the final beat of the current one leaves
  assign bus.memmuPayloadReady = !i_SYSTEM_rst && ((state == IDLE) || (handshake && outLast));
  assign acceptPayload = bus.memmuPayloadValid && bus.memmuPayloadReady;

  // FSM state register
  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state plus next contents of the holding and output registers
  always_comb begin
    stateNext     = state;
    heldM1Next    = heldM1;
    heldDist1Next = heldDist1;
    heldRefl1Next = heldRefl1;
    outValidNext  = outValid;
    outDistNext   = outDist;
    outReflNext   = outRefl;
    outIdxNext    = outIdx;
    outCorrNext   = outCorr;
    outLabelNext  = outLabel;
    outLastNext   = outLast;

    if (acceptPayload) begin
      heldM1Next    = inM1;
      heldDist1Next = inFields.distR1;
      heldRefl1Next = inFields.reflR1;
      outCorrNext   = inFields.correction;
      outLabelNext  = inFields.label;
      if (inM0) begin
        stateNext    = EMIT_R0;
        outValidNext = 1'b1;
        outDistNext  = inFields.distR0;
        outReflNext  = inFields.reflR0;
        outIdxNext   = 1'b0;
        outLastNext  = !inM1;
      end else if (inM1) begin
        stateNext    = EMIT_R1;
        outValidNext = 1'b1;
        outDistNext  = inFields.distR1;
        outReflNext  = inFields.reflR1;
        outIdxNext   = 1'b1;
        outLastNext  = 1'b1;
      end else begin
        // Both returns empty: the word is consumed without producing a beat
        stateNext    = IDLE;
        outValidNext = 1'b0;
        outLastNext  = 1'b0;
      end
    end else if (handshake) begin
      if ((state == EMIT_R0) && heldM1) begin
        stateNext    = EMIT_R1;
        outValidNext = 1'b1;
        outDistNext  = heldDist1;
        outReflNext  = heldRefl1;
        outIdxNext   = 1'b1;
        outLastNext  = 1'b1;
      end else begin
        stateNext    = IDLE;
        outValidNext = 1'b0;
        outLastNext  = 1'b0;
      end
    end
  end

  // Holding and output registers; reset wipes any partially emitted payload
  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      heldM1    <= 1'b0;
      heldDist1 <= '0;
      heldRefl1 <= '0;
      outValid  <= 1'b0;
      outDist   <= '0;
      outRefl   <= '0;
      outIdx    <= 1'b0;
      outCorr   <= '0;
      outLabel  <= '0;
      outLast   <= 1'b0;
    end else begin
      heldM1    <= heldM1Next;
      heldDist1 <= heldDist1Next;
      heldRefl1 <= heldRefl1Next;
      outValid  <= outValidNext;
      outDist   <= outDistNext;
      outRefl   <= outReflNext;
      outIdx    <= outIdxNext;
      outCorr   <= outCorrNext;
      outLabel  <= outLabelNext;
      outLast   <= outLastNext;
    end
  end

  assign bus.srValid      = outValid;
  assign bus.srDist       = outDist;
  assign bus.srRefl       = outRefl;
  assign bus.srReturnIdx  = outIdx;
  assign bus.srCorrection = outCorr;
  assign bus.srLabel      = outLabel;
  assign bus.srLast       = outLast;

`ifdef MEMMU_SR_U_STATS_EN
  logic [31:0] payloadCnt;
  logic [31:0] beatCnt;
  logic [15:0] emptyCnt;

  // Free-running wrap-around event counters
  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      payloadCnt <= '0;
      beatCnt    <= '0;
      emptyCnt   <= '0;
    end else begin
      if (acceptPayload) begin
        payloadCnt <= payloadCnt + 32'd1;
      end
      if (handshake) begin
        beatCnt <= beatCnt + 32'd1;
      end
      if (acceptPayload && !inM0 && !inM1) begin
        emptyCnt <= emptyCnt + 16'd1;
      end
    end
  end

  assign bus.srPayloadCnt = payloadCnt;
  assign bus.srBeatCnt    = beatCnt;
  assign bus.srEmptyCnt   = emptyCnt;
`endif

endmodule

// File: tb/tb_memmu_sr_payload_unpacker.sv
// tb/tb_memmu_sr_payload_unpacker.sv - directed table-driven bench for the SR payload unpacker
module tb_memmu_sr_payload_unpacker;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  memmu_sr_payload_unpacker_if busIf ();

  memmu_sr_payload_unpacker dut (
    .i_SYSTEM_clk (clk),
    .i_SYSTEM_rst (rst),
    .bus          (busIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] payload;
    int          nBeats;
    logic [15:0] d0;
    logic [7:0]  r0;
    logic        i0;
    logic        l0;
    logic [15:0] d1;
    logic [7:0]  r1;
    logic        i1;
    logic        l1;
    logic [7:0]  corr;
    logic [7:0]  label;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {valid, dist, refl, idx, last, corr, label, payloadReady}
  function automatic logic [63:0] actBeat();
    return {20'h0, busIf.srValid, busIf.srDist, busIf.srRefl, busIf.srReturnIdx, busIf.srLast,
            busIf.srCorrection, busIf.srLabel, busIf.memmuPayloadReady};
  endfunction

  function automatic logic [63:0] expBeat(input logic v, input logic [15:0] d, input logic [7:0] r,
                                          input logic i, input logic l, input logic [7:0] c,
                                          input logic [7:0] lab, input logic pr);
    return {20'h0, v, d, r, i, l, c, lab, pr};
  endfunction

  function automatic logic [63:0] idleState();
    return {62'h0, busIf.srValid, busIf.memmuPayloadReady};
  endfunction

  // Present one word with sink always ready and check it is taken on the next edge
  task automatic sendOne(input logic [63:0] p, input string name);
    @(negedge clk);
    busIf.memmuPayload      = p;
    busIf.memmuPayloadValid = 1'b1;
    busIf.srReady           = 1'b1;
    #1;
    check({name, "_accept_rdy"}, {63'h0, busIf.memmuPayloadReady}, 64'h1);
    @(posedge clk);
    #1;
    busIf.memmuPayloadValid = 1'b0;
  endtask

  logic [63:0] b2bPl[3];
  logic [41:0] b2bExp[6];
  logic [41:0] gotBeat[$];
  int          gotCyc[$];

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{64'h2A05_3304_567F_1234, 2, 16'h1234, 8'h7F, 1'b0, 1'b0, 16'h0456, 8'h33, 1'b1, 1'b1, 8'h05, 8'h2A};
    vecs[1] = '{64'h1122_4400_0055_0100, 1, 16'h0100, 8'h55, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h22, 8'h11};
    vecs[2] = '{64'h7766_99BE_EF88_0000, 1, 16'hBEEF, 8'h99, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h66, 8'h77};
    vecs[3] = '{64'hFFEE_DD00_00CC_0000, 0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'hEE, 8'hFF};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF};

    b2bPl[0] = 64'h2A05_3304_567F_1234;
    b2bPl[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    b2bPl[2] = 64'h0102_0304_0506_0708;
    b2bExp[0] = {16'h1234, 8'h7F, 1'b0, 1'b0, 8'h05, 8'h2A};
    b2bExp[1] = {16'h0456, 8'h33, 1'b1, 1'b1, 8'h05, 8'h2A};
    b2bExp[2] = {16'hFFFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hFF};
    b2bExp[3] = {16'hFFFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF};
    b2bExp[4] = {16'h0708, 8'h06, 1'b0, 1'b0, 8'h02, 8'h01};
    b2bExp[5] = {16'h0405, 8'h03, 1'b1, 1'b1, 8'h02, 8'h01};

    rst                     = 1'b1;
    busIf.memmuPayload      = '0;
    busIf.memmuPayloadValid = 1'b0;
    busIf.srReady           = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", actBeat(), 64'h0);
    rst = 1'b0;
    #1;
    check("post_reset_rdy", idleState(), 64'h1);

    // Table-driven single payloads
    for (int v = 0; v < 5; v++) begin
      sendOne(vecs[v].payload, $sformatf("vec%0d", v));
      if (vecs[v].nBeats > 0) begin
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_beat0", v), actBeat(),
              expBeat(1'b1, vecs[v].d0, vecs[v].r0, vecs[v].i0, vecs[v].l0, vecs[v].corr, vecs[v].label, vecs[v].l0));
      end
      if (vecs[v].nBeats > 1) begin
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_beat1", v), actBeat(),
              expBeat(1'b1, vecs[v].d1, vecs[v].r1, vecs[v].i1, vecs[v].l1, vecs[v].corr, vecs[v].label, vecs[v].l1));
      end
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_idle", v), idleState(), 64'h1);
    end

`ifdef MEMMU_SR_U_STATS_EN
    check("stats_payloadCnt", {32'h0, busIf.srPayloadCnt}, 64'd5);
    check("stats_beatCnt", {32'h0, busIf.srBeatCnt}, 64'd6);
    check("stats_emptyCnt", {48'h0, busIf.srEmptyCnt}, 64'd1);
`endif

    // Back-to-back payloads: six beats in consecutive cycles
    begin
      int k;
      logic acc;
      k = 0;
      @(negedge clk);
      busIf.memmuPayload      = b2bPl[0];
      busIf.memmuPayloadValid = 1'b1;
      busIf.srReady           = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
        if (cyc > 0) @(negedge clk);
        #1;
        if (busIf.srValid) begin
          gotBeat.push_back({busIf.srDist, busIf.srRefl, busIf.srReturnIdx, busIf.srLast,
                             busIf.srCorrection, busIf.srLabel});
          gotCyc.push_back(cyc);
        end
        acc = busIf.memmuPayloadValid && busIf.memmuPayloadReady;
        @(posedge clk);
        #1;
        if (acc) begin
          k++;
          if (k < 3) busIf.memmuPayload = b2bPl[k];
          else busIf.memmuPayloadValid = 1'b0;
        end
      end
      check("b2b_count", 64'(gotBeat.size()), 64'd6);
      if (gotBeat.size() == 6) begin
        check("b2b_first_cycle", 64'(gotCyc[0]), 64'd1);
        for (int i = 0; i < 6; i++) begin
          check($sformatf("b2b_beat%0d", i), {22'h0, gotBeat[i]}, {22'h0, b2bExp[i]});
          check($sformatf("b2b_cycle%0d", i), 64'(gotCyc[i] - gotCyc[0]), 64'(i));
        end
      end
    end

    // Stall on the R0 beat for 5 cycles
    sendOne(b2bPl[0], "stall");
    busIf.srReady = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      check($sformatf("stall_hold%0d", s), actBeat(),
            expBeat(1'b1, 16'h1234, 8'h7F, 1'b0, 1'b0, 8'h05, 8'h2A, 1'b0));
    end
    @(negedge clk);
    busIf.srReady = 1'b1;
    #1;
    check("stall_resume_r0", actBeat(), expBeat(1'b1, 16'h1234, 8'h7F, 1'b0, 1'b0, 8'h05, 8'h2A, 1'b0));
    @(negedge clk);
    #1;
    check("stall_resume_r1", actBeat(), expBeat(1'b1, 16'h0456, 8'h33, 1'b1, 1'b1, 8'h05, 8'h2A, 1'b1));
    @(negedge clk);
    #1;
    check("stall_idle", idleState(), 64'h1);

    // Reset asserted while the R1 beat is presented
    sendOne(b2bPl[0], "rstmid");
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstmid_r1_shown", actBeat(), expBeat(1'b1, 16'h0456, 8'h33, 1'b1, 1'b1, 8'h05, 8'h2A, 1'b1));
    busIf.srReady = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_outputs_zero", actBeat(), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    busIf.srReady = 1'b1;
    #1;
    check("rstmid_release_idle", idleState(), 64'h1);
    sendOne(vecs[1].payload, "rstmid_next");
    @(negedge clk);
    #1;
    check("rstmid_next_r0", actBeat(), expBeat(1'b1, 16'h0100, 8'h55, 1'b0, 1'b1, 8'h22, 8'h11, 1'b1));
    @(negedge clk);
    #1;
    check("rstmid_no_stale", idleState(), 64'h1);
`ifdef MEMMU_SR_U_STATS_EN
    check("rstmid_stats_payloadCnt", {32'h0, busIf.srPayloadCnt}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
